fifo_rd_drain: RTL and testbench

Read-side drain engine for the asynchronous FIFO, living entirely in the read clock domain. It pops a commanded number of words from the FIFO read port (`rinc`/`rdata`/`empty`) and re-issues them on a registered valid/ready stream through a 2-entry output buffer. It pulses `done` when the last word has been accepted downstream. It is the consumer counterpart to the FIFO write-side producer.

---
 rtl/fifo_rd_drain.sv | 130 +++++++++++++
 tb/tb_fifo_rd_drain.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side drain engine: pops a commanded burst from a show-ahead FIFO into a 2-entry valid/ready output buffer
// Optional popped-data pattern checker enabled by defining FIFO_RD_CHECK_EN.
module fifo_rd_drain #(
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          rclk,
    input  logic          rst,
    input  logic          empty,
    input  logic [DW-1:0] rdata,
    output logic          rinc,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] word_cnt,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [LW-1:0] remain;
    logic [1:0]    buf_cnt;
    logic [DW-1:0] buf_head;
    logic [DW-1:0] buf_tail;
    logic          xfer;

    // Pop decision never looks at m_ready, so downstream stalls cannot form a combinational loop into the FIFO.
    assign rinc    = (state == RUN) && !empty && (buf_cnt < 2'd2);
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_head;
    assign xfer    = m_valid && m_ready;

    always_ff @(posedge rclk) begin
        if (rst) begin
            buf_cnt  <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            case ({rinc, xfer})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_head <= rdata;
                    end else begin
                        buf_tail <= rdata;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                // Push and pop together only happen with one entry held, so the new word becomes the head.
                2'b11: buf_head <= rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state    <= IDLE;
            remain   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            remain   <= len;
                            word_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rinc) begin
                        remain   <= remain - LW'(1);
                        word_cnt <= word_cnt + LW'(1);
                        if (remain == LW'(1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Finish on the edge that empties the buffer so done lands one cycle after the last transfer.
                    if ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && xfer)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_CHECK_EN
    logic [DW-1:0] exp;

    always_ff @(posedge rclk) begin
        if (rst) begin
            exp <= '0;
            err <= 1'b0;
        end else if (rinc) begin
            exp <= exp + DW'(1);
            if (rdata != exp) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - randomized scoreboard bench for fifo_rd_drain with a queue-based FIFO and burst model
module tb_fifo_rd_drain;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          rclk = 1'b0;
    logic          rst = 1'b1;
    logic          empty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rinc;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [LW-1:0] word_cnt;
    logic          err;

    fifo_rd_drain #(.DW(DW), .LW(LW)) dut (
        .rclk(rclk), .rst(rst), .empty(empty), .rdata(rdata), .rinc(rinc),
        .start(start), .len(len), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .done(done), .word_cnt(word_cnt), .err(err)
    );

    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] exp_q[$];

    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [LW-1:0] m_wc = '0;
    int            popped = 0;
    int            burst_len = 0;
    int            occ = 0;
    int            pidx = 0;
    logic          err_exp = 1'b0;
    logic          pop_pending = 1'b0;
    logic          rst_pending = 1'b0;
    logic          armed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: FIFO model update, scoreboard compare and spec-level burst model.
    initial begin
        logic b, pop, xfer, exp_rinc;
        forever begin
            @(negedge rclk);
            #1;
            if (pop_pending) void'(fifo_q.pop_front());
            if (rst_pending) ref_q = fifo_q;
            empty = (fifo_q.size() == 0);
            rdata = empty ? '0 : fifo_q[0];
            #1;
            if (armed) begin
                if (rst_pending)
                    chk("reset_outputs", {rinc, m_valid, m_data, busy, done, word_cnt, err}, 64'd0);
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                chk("word_cnt", word_cnt, m_wc);
                chk("err", err, err_exp);
                chk("m_valid", m_valid, occ != 0);
                exp_rinc = m_busy && (popped < burst_len) && !empty && (occ < 2);
                chk("rinc", rinc, exp_rinc);
            end
            b    = m_busy;
            pop  = rinc && !empty;
            xfer = m_valid && m_ready;
            m_done = 1'b0;
            if (xfer && armed) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", m_data, $time);
                end else begin
                    chk("m_data", m_data, exp_q.pop_front());
                end
            end
            pop_pending = pop;
            if (rst) begin
                m_busy = 1'b0; m_wc = '0; popped = 0; burst_len = 0; occ = 0;
                pidx = 0; err_exp = 1'b0; exp_q.delete();
                rst_pending = 1'b1;
                armed = 1'b1;
            end else begin
                rst_pending = 1'b0;
                if (pop) begin
`ifdef FIFO_RD_CHECK_EN
                    if (rdata != DW'(pidx)) err_exp = 1'b1;
`endif
                    pidx++;
                    popped++;
                    m_wc = m_wc + LW'(1);
                    occ++;
                end
                if (xfer) begin
                    occ--;
                    if (b && exp_q.size() == 0) begin
                        m_done = 1'b1;
                        m_busy = 1'b0;
                    end
                end
                if (start && !b) begin
                    if (len != 0) begin
                        m_busy = 1'b1; m_wc = '0; popped = 0; burst_len = int'(len);
                        for (int i = 0; i < int'(len); i++) begin
                            if (ref_q.size() != 0) exp_q.push_back(ref_q.pop_front());
                        end
                    end else begin
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic load(input logic [DW-1:0] w);
        ref_q.push_back(w);
        fifo_q.push_back(w);
    endtask

    task automatic plan(input logic [DW-1:0] w);
        ref_q.push_back(w);
        feed_q.push_back(w);
    endtask

    task automatic go(input int n);
        @(negedge rclk);
        start = 1'b1;
        len   = LW'(n);
        @(negedge rclk);
        start = 1'b0;
    endtask

    task automatic drive_ready(input int mode);
        case (mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic cycles(input int n, input int rmode);
        for (int c = 0; c < n; c++) begin
            @(negedge rclk);
            drive_ready(rmode);
        end
    endtask

    // feed: 0 none, 1 all pending words at once, 2 one word with probability 1/2
    task automatic wait_idle(input int rmode, input int feed, input int max);
        bit ok = 0;
        for (int c = 0; c < max; c++) begin
            @(negedge rclk);
            drive_ready(rmode);
            if (feed == 1) begin
                while (feed_q.size() != 0) fifo_q.push_back(feed_q.pop_front());
            end else if (feed == 2 && feed_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                fifo_q.push_back(feed_q.pop_front());
            end
            if (exp_q.size() == 0 && !m_busy && feed_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: burst still open after %0d cycles", max);
        end
        cycles(2, 0);
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rst = 1'b1;
        @(negedge rclk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge rclk);
        rst = 1'b0;

        // Basic 10-word drain with m_ready held high.
        for (int i = 0; i < 10; i++) load(DW'(i));
        go(10);
        wait_idle(0, 0, 100);
        chk("word_cnt_10", word_cnt, 10);

        // Same preload with m_ready toggling every cycle.
        for (int i = 0; i < 10; i++) load(DW'(i));
        go(10);
        wait_idle(1, 0, 200);

        // Downstream stalled: buffer fills to two then pops stop.
        for (int i = 0; i < 6; i++) load(DW'($urandom));
        go(6);
        cycles(10, 3);
        chk("stall_word_cnt", word_cnt, 2);
        wait_idle(0, 0, 100);

        // FIFO empty for 20 cycles, then 5 words arrive.
        for (int i = 0; i < 5; i++) plan(DW'($urandom));
        go(5);
        cycles(20, 0);
        chk("busy_while_empty", busy, 1);
        wait_idle(0, 1, 100);
        chk("fifo_left_empty", fifo_q.size(), 0);

        // len=0 and a start issued during an active burst.
        go(0);
        cycles(2, 0);
        for (int i = 0; i < 4; i++) load(DW'($urandom));
        go(4);
        go(3);
        wait_idle(0, 0, 100);

        // Reset after three pops of an 8-word burst, then resume.
        for (int i = 0; i < 8; i++) load(DW'($urandom));
        go(8);
        for (int c = 0; c < 50 && m_wc < 3; c++) @(negedge rclk);
        rst = 1'b1;
        @(negedge rclk);
        rst = 1'b0;
        go(2);
        wait_idle(0, 0, 100);
        n = ref_q.size();
        if (n > 0) begin
            go(n);
            wait_idle(2, 0, 200);
        end

        // Maximum length: word_cnt must reach 255 without wrapping.
        for (int i = 0; i < 255; i++) load(DW'($urandom));
        go(255);
        wait_idle(0, 0, 600);
        chk("word_cnt_max", word_cnt, 255);

        // Randomized bursts with gappy FIFO and random backpressure.
        for (int k = 0; k < 15; k++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) plan(DW'($urandom));
            go(n);
            wait_idle(2, 2, 300);
        end

        // Pattern checker: third word breaks the 0,1,2 sequence.
        do_reset();
        load(8'h00); load(8'h01); load(8'h05);
        go(3);
        wait_idle(0, 0, 100);
`ifdef FIFO_RD_CHECK_EN
        chk("err_final", err, 1);
`else
        chk("err_final", err, 0);
`endif

        cycles(3, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
